// File: rtl/refr_row_sequencer.sv
// Turns per-cycle refresh grants into bank+row refresh commands, paces rounds
// with an interval timer, throttles the scheduler and counts late rounds.
module refr_row_sequencer #(
  parameter int NUMRBNK = 4,
  parameter int BITRBNK = 2,
  parameter int NUMRROW = 64,
  parameter int BITRROW = 6,
  parameter int REFRINT = 256,
  parameter int BITRINT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prefr,
  input  logic [BITRBNK-1:0] prfbadr,
  output logic               norefr,
  output logic               rrefr,
  output logic [BITRBNK-1:0] rrfbadr,
  output logic [BITRROW-1:0] rrfradr,
  output logic               rlate,
  output logic [7:0]         rlatecnt
);

  logic [BITRINT-1:0] timer_reg;
  logic [NUMRBNK-1:0] done_reg;
  logic [BITRROW-1:0] rowptr_reg [NUMRBNK];
  logic [NUMRBNK-1:0] hit;
  logic [NUMRBNK-1:0] fin;
  logic [31:0]        badr_ext;
  logic               acc;
  logic               tick;
  logic [BITRROW-1:0] sel_row;

  logic               s1_vld_reg;
  logic [BITRBNK-1:0] s1_bank_reg;
  logic [BITRROW-1:0] s1_row_reg;

  // Throttle comes straight from the bitmap flops, never from prefr.
  assign norefr   = &done_reg;
  assign badr_ext = 32'(prfbadr);
  assign acc      = prefr && !norefr && (badr_ext < 32'(NUMRBNK));
  assign tick     = (timer_reg == BITRINT'(REFRINT - 1));
  assign fin      = done_reg | hit;

  generate
    for (genvar gi = 0; gi < NUMRBNK; gi++) begin : g_hit
      assign hit[gi] = acc && (badr_ext == 32'(gi));
    end
  endgenerate

  always_comb begin
    sel_row = '0;
    for (int i = 0; i < NUMRBNK; i++) begin
      if (hit[i]) sel_row = rowptr_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUMRBNK; i++) rowptr_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUMRBNK; i++) begin
        if (hit[i]) begin
          rowptr_reg[i] <= (rowptr_reg[i] == BITRROW'(NUMRROW - 1)) ?
                           '0 : rowptr_reg[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg   <= '0;
      done_reg    <= '0;
      rlate       <= 1'b0;
      rlatecnt    <= '0;
      s1_vld_reg  <= 1'b0;
      s1_bank_reg <= '0;
      s1_row_reg  <= '0;
      rrefr       <= 1'b0;
      rrfbadr     <= '0;
      rrfradr     <= '0;
    end else begin
      timer_reg <= tick ? '0 : timer_reg + 1'b1;
      // A tick-cycle accept counts for the ending round but its done bit is dropped.
      done_reg  <= tick ? '0 : fin;
      rlate     <= tick && !(&fin);
      if (tick && !(&fin) && (rlatecnt != 8'hff)) rlatecnt <= rlatecnt + 8'd1;

      s1_vld_reg  <= acc;
      s1_bank_reg <= prfbadr;
      s1_row_reg  <= sel_row;
      rrefr       <= s1_vld_reg;
      rrfbadr     <= s1_bank_reg;
      rrfradr     <= s1_row_reg;
    end
  end

endmodule

// File: tb/tb_refr_row_sequencer.sv
// Scoreboard bench for refr_row_sequencer: a behavioural model predicts each
// command, the throttle and the late-round counters cycle by cycle.
module tb_refr_row_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prefr = 1'b0;
  logic [1:0] prfbadr = 2'd0;
  logic       norefr;
  logic       rrefr;
  logic [1:0] rrfbadr;
  logic [1:0] rrfradr;
  logic       rlate;
  logic [7:0] rlatecnt;

  refr_row_sequencer #(
    .NUMRBNK(4), .BITRBNK(2), .NUMRROW(4), .BITRROW(2), .REFRINT(16), .BITRINT(4)
  ) dut (
    .clk(clk), .rst(rst), .prefr(prefr), .prfbadr(prfbadr),
    .norefr(norefr), .rrefr(rrefr), .rrfbadr(rrfbadr), .rrfradr(rrfradr),
    .rlate(rlate), .rlatecnt(rlatecnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int bank;
    int row;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int         m_timer;
  logic [3:0] m_done;
  int         m_rowptr[4];
  logic       m_rlate;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_timer = 0;
    m_done  = 4'b0;
    for (int i = 0; i < 4; i++) m_rowptr[i] = 0;
    m_rlate = 1'b0;
    m_cnt   = 0;
    q.delete();
  endtask

  // Entered 1 time unit after a rising edge; holds rst for one edge, then cycle 0 begins.
  task automatic do_reset();
    rst = 1'b1;
    prefr = 1'b0;
    prfbadr = 2'd0;
    @(posedge clk); #1;
    chk("rst_norefr", 32'(norefr), 32'd0);
    chk("rst_rrefr", 32'(rrefr), 32'd0);
    chk("rst_rrfbadr", 32'(rrfbadr), 32'd0);
    chk("rst_rrfradr", 32'(rrfradr), 32'd0);
    chk("rst_rlate", 32'(rlate), 32'd0);
    chk("rst_rlatecnt", 32'(rlatecnt), 32'd0);
    rst = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  task automatic step(input logic p, input int b);
    exp_t       e;
    logic       acc;
    logic       tick;
    logic [3:0] fin;
    prefr   = p;
    prfbadr = 2'(b);
    @(negedge clk);
    chk("norefr", 32'(norefr), 32'(&m_done));
    chk("rlate", 32'(rlate), 32'(m_rlate));
    chk("rlatecnt", 32'(rlatecnt), 32'(m_cnt));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rrefr", 32'(rrefr), 32'd1);
      chk("rrfbadr", 32'(rrfbadr), 32'(e.bank));
      chk("rrfradr", 32'(rrfradr), 32'(e.row));
    end else begin
      chk("rrefr_idle", 32'(rrefr), 32'd0);
    end
    acc  = p && !(&m_done) && (b < 4);
    tick = (m_timer == 15);
    fin  = m_done;
    if (acc) begin
      fin[b] = 1'b1;
      q.push_back('{cyc + 2, b, m_rowptr[b]});
      m_rowptr[b] = (m_rowptr[b] + 1) % 4;
    end
    m_rlate = tick && (fin != 4'hf);
    if (m_rlate && m_cnt < 255) m_cnt++;
    m_done  = tick ? 4'b0 : fin;
    m_timer = (m_timer + 1) % 16;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  initial begin
    @(posedge clk); #1;

    // Latency: bank 2 at cycle 3 and again at cycle 20
    do_reset();
    idle(3);
    step(1'b1, 2);
    idle(16);
    step(1'b1, 2);
    idle(4);

    // Throttle: all banks in cycles 1-4, rejected grant at cycle 8
    do_reset();
    idle(1);
    for (int b = 0; b < 4; b++) step(1'b1, b);
    idle(3);
    step(1'b1, 1);
    idle(7);
    chk("throttle_norefr_c16", 32'(norefr), 32'd0);
    idle(3);

    // Late rounds: banks 0,1,2 only, 300 rounds
    do_reset();
    for (int r = 0; r < 300; r++) begin
      idle(1);
      for (int b = 0; b < 3; b++) step(1'b1, b);
      idle(12);
    end
    chk("late_rlate", 32'(rlate), 32'd1);
    chk("late_sat_cnt", 32'(rlatecnt), 32'd255);
    idle(2);

    // Tick-cycle completion: bank 3 at cycle 15
    do_reset();
    idle(1);
    for (int b = 0; b < 3; b++) step(1'b1, b);
    idle(11);
    step(1'b1, 3);
    chk("tickc_rlate", 32'(rlate), 32'd0);
    chk("tickc_norefr", 32'(norefr), 32'd0);
    idle(3);

    // Row wrap: bank 0 once per round for 5 rounds
    do_reset();
    for (int r = 0; r < 5; r++) begin
      idle(1);
      step(1'b1, 0);
      idle(14);
    end
    idle(2);

    // Back-to-back bank 1 grants in cycles 2,3
    do_reset();
    idle(2);
    step(1'b1, 1);
    step(1'b1, 1);
    idle(4);

    // Reset mid-flight: accept in cycle 2, rst in cycle 3
    do_reset();
    idle(2);
    step(1'b1, 3);
    do_reset();
    step(1'b1, 3);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/refr_row_sequencer.md
# refr_row_sequencer

Downstream companion of the refresh bank scheduler. It accepts the scheduler's per-cycle refresh grant (bank address) and turns it into a fully-addressed refresh command (bank + row). Per-bank row pointers advance round-robin. It paces refresh rounds with an interval timer and throttles the scheduler through `norefr` once every bank has been refreshed in the current round. The command is delayed two cycles to line up with the third stage of the access pipeline. It also flags rounds that miss their deadline.

## Interface
- `NUMRBNK`, 4: number of refresh banks.
- `BITRBNK`, 2: bank address width.
- `NUMRROW`, 64: rows per bank.
- `BITRROW`, 6: row address width.
- `REFRINT`, 256: cycles per refresh round (≥ NUMRBNK+1).
- `BITRINT`, 8: interval timer width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `prefr` in 1: refresh grant from the scheduler.
- `prfbadr` in BITRBNK: granted bank.
- `norefr` out 1: inhibit to the scheduler; high when all banks are done this round.
- `rrefr` out 1: refresh command valid to the memory banks.
- `rrfbadr` out BITRBNK: command bank.
- `rrfradr` out BITRROW: command row.
- `rlate` out 1: one-cycle pulse when a round ends incomplete.
- `rlatecnt` out 8: count of late rounds, saturating at 255.

## Operation
- **Interval timer:** counts 0..REFRINT-1, then wraps to 0.
  - The tick cycle is timer == REFRINT-1.
- **Done bitmap:** `done[NUMRBNK-1:0]`, one bit per bank.
  - `norefr = &done`, driven from flops only; no combinational path from `prefr`.
- **Accept:** `acc = prefr && !norefr && (prfbadr < NUMRBNK)`.
  - Out-of-range bank addresses are silently dropped.
- **On accept:**
  - Capture bank b and `rowptr[b]`.
  - `rowptr[b]` becomes 0 if it equals NUMRROW-1; otherwise `rowptr[b] + 1`.
  - Set `done[b]`.
  - A repeat grant to a bank already done is still accepted and advances that bank's row. This cannot happen once `norefr` is high.
- **Tick cycle:**
  - `fin = done | onehot(acc ? prfbadr : none)`.
  - If `fin` is not all ones: pulse `rlate` and increment `rlatecnt`, saturating.
  - Clear `done` to 0 at the next edge. The clear overrides any set from the tick-cycle accept; that accept still counts toward the ending round.
- **Output pipeline:** two register stages, each holding `{vld, bank, row}`.
  - Stage 1 loads `{acc, b, rowptr[b]}`.
  - Stage 2 drives `rrefr`, `rrfbadr`, `rrfradr`.
  - No stall; a new command may be issued every cycle.
- **Reset values:**
  - Timer 0; all `rowptr` 0; `done` 0; both stage valids 0.
  - Outputs: `norefr` 0, `rrefr` 0, `rrfbadr` 0, `rrfradr` 0, `rlate` 0, `rlatecnt` 0.
- **Reset mid-operation:** in-flight pipeline commands are discarded; their row advances are lost (pointers return to 0).

## Timing
- Cycle 0 is the first cycle with `rst` low; timer = 0 in cycle 0.
- **Command latency:** accept in cycle t gives `rrefr` = 1 in cycle t+2 with that cycle's bank and row.
- **`norefr` rise:** the cycle after the accept that completes the bitmap.
- **`norefr` fall:** the cycle after the tick.
  - If the completing accept occurs on the tick, `norefr` stays 0.
- **`rlate`:** high for exactly the one cycle after the tick. `rlatecnt` updates in the same cycle.
- **Row pointer read:**
  - Same-cycle grants always read the pre-increment pointer.
  - Back-to-back grants to one bank yield consecutive rows in consecutive cycles.

## Test plan
All scenarios use NUMRBNK=4, NUMRROW=4, REFRINT=16.
- **Latency:** `prefr` bank 2 in cycle 3 → `rrefr` in cycle 5 with bank 2, row 0. Bank 2 granted again in cycle 20 → cycle 22 gives row 1.
- **Throttle:** banks 0,1,2,3 granted in cycles 1–4 → `norefr` high in cycles 5–15, low in cycle 16. A `prefr` in cycle 8 produces no `rrefr` in cycle 10.
- **Late round:** only banks 0,1,2 granted before cycle 15 → `rlate` = 1 in cycle 16 only, `rlatecnt` = 1. After 300 such rounds, `rlatecnt` = 255.
- **Tick-cycle completion:** banks 0,1,2 in cycles 1–3, bank 3 in cycle 15 → no `rlate`. `norefr` stays 0. `rrefr` for bank 3, row 0 in cycle 17.
- **Row wrap:** bank 0 granted once per round for 5 rounds → rows 0,1,2,3,0. Back-to-back bank 1 grants in cycles 2,3 → rows 0,1 in cycles 4,5.
- **Reset mid-flight:** accept in cycle t, `rst` in cycle t+1 → no `rrefr` in cycle t+2. All outputs are at reset values. The next grant to that bank returns row 0.
